tt_pin_trace: RTL and testbench



---
 rtl/tt_pin_trace_if.sv | 35 +++
 rtl/tt_pin_trace.sv | 163 ++++++++++++++++
 tb/tb_tt_pin_trace.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tt_pin_trace_if.sv
// Bundle of the control, sample and read-side signals of the pin-activity trace.
// The harness or bench drives through master; the trace block sits on slave.
interface tt_pin_trace_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 16
);
  localparam int SW = CHANNELS * WIDTH;
  localparam int DW = TS_W + CHANNELS + SW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ena;
  logic          arm;
  logic          clear;
  logic [SW-1:0] sample_in;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [1:0]    state;

  modport master (
    output ena, arm, clear, sample_in, rd_en,
    input  rd_data, rd_valid, empty, full, count, overflow, state
  );

  modport slave (
    input  ena, arm, clear, sample_in, rd_en,
    output rd_data, rd_valid, empty, full, count, overflow, state
  );
endinterface

// File: rtl/tt_pin_trace.sv
// Pin-activity trace: samples CHANNELS buses, pushes {timestamp, change mask, sample}
// into a FIFO whenever any bus changes, and lets the harness drain it one entry per pop.
module tt_pin_trace #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 3,
  parameter int DEPTH        = 16,
  parameter int TS_W         = 16,
  parameter int STOP_ON_FULL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_pin_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = CHANNELS * WIDTH;
  localparam int DW = TS_W + CHANNELS + SW;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    STOPPED = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count_q;
  logic [TS_W-1:0]     ts;
  logic [SW-1:0]       prev;
  logic                first;
  logic                overflow_q;
  logic                rd_valid_q;
  logic [DW-1:0]       rd_data_q;
  logic [CHANNELS-1:0] chg_mask;
  logic [CHANNELS-1:0] push_mask;
  logic                sampling;
  logic                push_req;
  logic                push_ok;
  logic                pop_ok;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                arm_start;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    chg_mask = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      chg_mask[c] = (bus.sample_in[c*WIDTH +: WIDTH] != prev[c*WIDTH +: WIDTH]);
    end
  end

  // A full FIFO still accepts a push when a pop frees the slot in the same cycle;
  // an empty FIFO has nothing to pop, so only the push goes through.
  assign sampling  = (state_q == ARMED) && bus.arm && bus.ena && !bus.clear;
  assign push_mask = first ? '1 : chg_mask;
  assign push_req  = sampling && (first || (|chg_mask));
  assign pop_ok    = bus.rd_en && !fifo_empty && !bus.clear;
  assign push_ok   = push_req && (!fifo_full || pop_ok);
  assign drop      = push_req && fifo_full && !pop_ok;
  assign arm_start = (state_q == IDLE) && (state_d == ARMED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm && bus.ena) state_d = ARMED;
        end
        ARMED: begin
          if (!bus.arm) begin
            state_d = IDLE;
          end else if (drop && (STOP_ON_FULL != 0)) begin
            state_d = STOPPED;
          end
        end
        STOPPED: begin
          if (!bus.arm && fifo_empty) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The timestamp saturates rather than wraps so late entries never alias early ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts    <= '0;
      prev  <= '0;
      first <= 1'b1;
    end else if (bus.clear) begin
      ts <= '0;
    end else if (arm_start) begin
      ts    <= '0;
      first <= 1'b1;
    end else if (sampling) begin
      prev  <= bus.sample_in;
      first <= 1'b0;
      if (ts != '1) ts <= ts + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {ts, push_mask, bus.sample_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (bus.clear) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ok;
      if (pop_ok) rd_data_q <= mem[rd_ptr];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = fifo_empty;
  assign bus.full     = fifo_full;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_tt_pin_trace.sv
// Drives a drop-on-full and a stop-on-full trace side by side with directed vectors;
// popped entries are checked against a queue of hand-computed entries.
module tb_tt_pin_trace;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int DEPTH    = 16;
  localparam int TS_W     = 16;
  localparam int DW       = TS_W + CHANNELS + CHANNELS * WIDTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena, arm, clear, rd_en;
  logic [23:0] sample_in;

  always #5 clk = ~clk;

  tt_pin_trace_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)) bus0 ();
  tt_pin_trace_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W)) bus1 ();

  assign bus0.ena = ena;
  assign bus0.arm = arm;
  assign bus0.clear = clear;
  assign bus0.sample_in = sample_in;
  assign bus0.rd_en = rd_en;
  assign bus1.ena = ena;
  assign bus1.arm = arm;
  assign bus1.clear = clear;
  assign bus1.sample_in = sample_in;
  assign bus1.rd_en = rd_en;

  tt_pin_trace #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W),
                 .STOP_ON_FULL(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tt_pin_trace #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .TS_W(TS_W),
                 .STOP_ON_FULL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  logic [DW-1:0] e0, e1;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic e, input logic c,
                                input logic r, input logic [23:0] s);
    arm = a;
    ena = e;
    clear = c;
    rd_en = r;
    sample_in = s;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] entry(input logic [15:0] t, input logic [2:0] m,
                                          input logic [23:0] s);
    return {t, m, s};
  endfunction

  task automatic expect_pop(input logic [DW-1:0] d);
    exp0.push_back(d);
    exp1.push_back(d);
  endtask

  // Monitor: every rd_valid pulse consumes the oldest expected entry.
  always @(negedge clk) begin
    if (bus0.rd_valid === 1'b1) begin
      if (exp0.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL dut0 pop: got 0x%0h, expected no pop", bus0.rd_data);
      end else begin
        e0 = exp0.pop_front();
        check_output("dut0 pop data", 64'(bus0.rd_data), 64'(e0));
      end
    end
    if (bus1.rd_valid === 1'b1) begin
      if (exp1.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL dut1 pop: got 0x%0h, expected no pop", bus1.rd_data);
      end else begin
        e1 = exp1.pop_front();
        check_output("dut1 pop data", 64'(bus1.rd_data), 64'(e1));
      end
    end
  end

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    rst_n = 1'b0;
    #12;
    check_output("reset count", 64'(bus0.count), 64'd0);
    check_output("reset empty", 64'(bus0.empty), 64'd1);
    check_output("reset full", 64'(bus0.full), 64'd0);
    check_output("reset overflow", 64'(bus0.overflow), 64'd0);
    check_output("reset state", 64'(bus0.state), 64'd0);
    check_output("reset rd_valid", 64'(bus0.rd_valid), 64'd0);
    check_output("reset rd_data", 64'(bus0.rd_data), 64'd0);
    check_output("reset dut1 count", 64'(bus1.count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);

    // First entry, then channel changes at ts=5 and ts=9.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'h000000);
    step(6);
    check_output("single first entry dut0", 64'(bus0.count), 64'd1);
    check_output("single first entry dut1", 64'(bus1.count), 64'd1);
    check_output("armed state", 64'(bus0.state), 64'd1);
    sample_in = 24'h00A500;
    step(4);
    sample_in = 24'h00A53C;
    step(1);
    check_output("three entries", 64'(bus0.count), 64'd3);
    expect_pop(entry(16'd0, 3'b111, 24'h000000));
    expect_pop(entry(16'd5, 3'b010, 24'h00A500));
    expect_pop(entry(16'd9, 3'b001, 24'h00A53C));
    rd_en = 1'b1;
    step(3);
    rd_en = 1'b0;
    step(1);
    check_output("drained count", 64'(bus0.count), 64'd0);
    check_output("drained empty", 64'(bus0.empty), 64'd1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    check_output("pop on empty rd_valid", 64'(bus0.rd_valid), 64'd0);
    check_output("pop on empty rd_data hold", 64'(bus0.rd_data),
                 64'(entry(16'd9, 3'b001, 24'h00A53C)));
    arm = 1'b0;
    step(1);
    check_output("disarm state", 64'(bus0.state), 64'd0);

    // Fill both FIFOs with 16 changes, then push and pop together while full.
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    arm = 1'b1;
    step(1);
    for (int i = 1; i <= 16; i++) begin
      sample_in = (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      step(1);
    end
    check_output("fill dut0 count", 64'(bus0.count), 64'd16);
    check_output("fill dut0 full", 64'(bus0.full), 64'd1);
    check_output("fill dut0 overflow", 64'(bus0.overflow), 64'd0);
    check_output("fill dut1 count", 64'(bus1.count), 64'd16);
    expect_pop(entry(16'd0, 3'b111, 24'hFFFFFF));
    sample_in = 24'h123456;
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    check_output("push+pop full dut0 count", 64'(bus0.count), 64'd16);
    check_output("push+pop full dut0 overflow", 64'(bus0.overflow), 64'd0);
    check_output("push+pop full dut0 rd_valid", 64'(bus0.rd_valid), 64'd1);
    check_output("push+pop full dut1 count", 64'(bus1.count), 64'd16);
    check_output("push+pop full dut1 state", 64'(bus1.state), 64'd1);
    check_output("push+pop full dut1 overflow", 64'(bus1.overflow), 64'd0);

    // Four more changes with no reads overflow both FIFOs.
    for (int i = 0; i < 4; i++) begin
      sample_in = ~sample_in;
      step(1);
    end
    check_output("overflow dut0 count", 64'(bus0.count), 64'd16);
    check_output("overflow dut0 flag", 64'(bus0.overflow), 64'd1);
    check_output("overflow dut0 state", 64'(bus0.state), 64'd1);
    check_output("overflow dut1 count", 64'(bus1.count), 64'd16);
    check_output("overflow dut1 flag", 64'(bus1.overflow), 64'd1);
    check_output("overflow dut1 state", 64'(bus1.state), 64'd2);
    expect_pop(entry(16'd1, 3'b111, 24'h000000));
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    step(1);
    check_output("after pop dut0 count", 64'(bus0.count), 64'd15);
    check_output("after pop dut1 count", 64'(bus1.count), 64'd15);
    check_output("stopped holds", 64'(bus1.state), 64'd2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    arm = 1'b0;
    check_output("clear dut1 state", 64'(bus1.state), 64'd0);
    check_output("clear dut1 count", 64'(bus1.count), 64'd0);
    check_output("clear dut1 overflow", 64'(bus1.overflow), 64'd0);
    check_output("clear dut0 overflow", 64'(bus0.overflow), 64'd0);
    check_output("clear dut0 empty", 64'(bus0.empty), 64'd1);

    // Asynchronous reset in the middle of a capture.
    arm = 1'b1;
    step(1);
    for (int i = 1; i <= 7; i++) begin
      sample_in = (i % 2 == 1) ? 24'h0F0F0F : 24'hF0F0F0;
      step(1);
    end
    check_output("pre-reset count", 64'(bus0.count), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset count", 64'(bus0.count), 64'd0);
    check_output("async reset empty", 64'(bus0.empty), 64'd1);
    check_output("async reset state", 64'(bus0.state), 64'd0);
    check_output("async reset dut1 count", 64'(bus1.count), 64'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    check_output("dut0 all pops seen", 64'(exp0.size()), 64'd0);
    check_output("dut1 all pops seen", 64'(exp1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
